// File: rtl/alu_issue_ctrl_pkg.sv
// alu_issue_ctrl_pkg: ALU op codes and issue FSM state encodings
package alu_issue_ctrl_pkg;
    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_AND   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_NOT   = 4'd4;
    localparam logic [3:0] OP_XOR   = 4'd5;
    localparam logic [3:0] OP_NOR   = 4'd6;
    localparam logic [3:0] OP_SHL   = 4'd7;
    localparam logic [3:0] OP_SHR   = 4'd8;
    localparam logic [3:0] OP_ASR   = 4'd9;
    localparam logic [3:0] OP_ROL   = 4'd10;
    localparam logic [3:0] OP_ROR   = 4'd11;
    localparam logic [3:0] OP_EQ    = 4'd12;
    localparam logic [3:0] OP_LOADI = 4'd15;
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_WB   = 2'd2
    } state_e;
endpackage

// File: rtl/alu_issue_ctrl_regfile.sv
// alu_regfile: register file with one write port, two operand reads and a debug read
module alu_regfile
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_N  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr1_i,
    input  logic [ADDR_W-1:0] raddr2_i,
    input  logic [ADDR_W-1:0] raddr3_i,
    output logic [DATA_W-1:0] rdata1_o,
    output logic [DATA_W-1:0] rdata2_o,
    output logic [DATA_W-1:0] rdata3_o
);
    logic [DATA_W-1:0] mem_q [REG_N];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_N; i++) mem_q[i] <= '0;
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata1_o = mem_q[raddr1_i];
    assign rdata2_o = mem_q[raddr2_i];
    assign rdata3_o = mem_q[raddr3_i];
endmodule

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one instruction at a time to an external combinational ALU
// and writes its result back to the local register file and carry flag.
module alu_issue_ctrl
    import alu_issue_ctrl_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int REG_N  = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [3:0]        in_op,
    input  logic [ADDR_W-1:0] in_rd,
    input  logic [ADDR_W-1:0] in_rs1,
    input  logic [ADDR_W-1:0] in_rs2,
    input  logic [DATA_W-1:0] in_imm,
    output logic [3:0]        alu_ctrl,
    output logic [DATA_W-1:0] alu_x,
    output logic [DATA_W-1:0] alu_y,
    input  logic [DATA_W-1:0] alu_out,
    input  logic              alu_carry,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_carry,
    output logic              carry_flag,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);
    state_e            state_q, state_d;
    logic              xfer, is_loadi, op_go;
    logic [ADDR_W-1:0] rd_q, rd_d;
    logic [DATA_W-1:0] res_q, res_d, x_q, x_d, y_q, y_d, rs1_data, rs2_data;
    logic [3:0]        ctrl_q, ctrl_d;
    logic              cy_q, cy_d, flag_q, flag_d;

    assign xfer     = in_valid && in_ready;
    assign is_loadi = in_op == OP_LOADI;
    assign op_go    = xfer && !is_loadi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = (state_q == ST_IDLE) ? (xfer ? (is_loadi ? ST_WB : ST_EXEC) : ST_IDLE) :
                  (state_q == ST_EXEC) ? ST_WB : ST_IDLE;
    end

    always_comb begin
        in_ready = state_q == ST_IDLE;
        wb_valid = state_q == ST_WB;
    end

    // LOADI bypasses the ALU; EXEC captures the ALU's combinational result
    always_comb begin
        rd_d   = xfer ? in_rd : rd_q;
        res_d  = (xfer && is_loadi) ? in_imm : (state_q == ST_EXEC) ? alu_out : res_q;
        cy_d   = (xfer && is_loadi) ? 1'b0 : (state_q == ST_EXEC) ? alu_carry : cy_q;
        ctrl_d = op_go ? in_op : ctrl_q;
        x_d    = op_go ? rs1_data : x_q;
        y_d    = op_go ? rs2_data : y_q;
        flag_d = wb_valid ? cy_q : flag_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q   <= '0;
            res_q  <= '0;
            cy_q   <= 1'b0;
            ctrl_q <= '0;
            x_q    <= '0;
            y_q    <= '0;
            flag_q <= 1'b0;
        end else begin
            rd_q   <= rd_d;
            res_q  <= res_d;
            cy_q   <= cy_d;
            ctrl_q <= ctrl_d;
            x_q    <= x_d;
            y_q    <= y_d;
            flag_q <= flag_d;
        end
    end

    alu_regfile #(.DATA_W(DATA_W), .REG_N(REG_N), .ADDR_W(ADDR_W)) u_rf (
        .clk      (clk),
        .rst      (rst),
        .we_i     (wb_valid),
        .waddr_i  (rd_q),
        .wdata_i  (res_q),
        .raddr1_i (in_rs1),
        .raddr2_i (in_rs2),
        .raddr3_i (rd_addr),
        .rdata1_o (rs1_data),
        .rdata2_o (rs2_data),
        .rdata3_o (rd_data)
    );

    assign alu_ctrl   = ctrl_q;
    assign alu_x      = x_q;
    assign alu_y      = y_q;
    assign wb_addr    = rd_q;
    assign wb_data    = res_q;
    assign wb_carry   = cy_q;
    assign carry_flag = flag_q;
endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed table-driven bench with a behavioural ALU attached
module tb_alu_issue_ctrl;
    logic       clk = 0, rst = 1;
    logic       in_valid = 0, in_ready;
    logic [3:0] in_op = 0, alu_ctrl;
    logic [2:0] in_rd = 0, in_rs1 = 0, in_rs2 = 0, wb_addr, rd_addr = 0;
    logic [7:0] in_imm = 0, alu_x, alu_y, alu_out, wb_data, rd_data;
    logic       alu_carry, wb_valid, wb_carry, carry_flag;
    int         total = 0, passed = 0, cyc = 0, wb_cnt = 0;
    int         xfer_cyc[$];

    always #5 clk = ~clk;

    alu_issue_ctrl dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
        .alu_ctrl(alu_ctrl), .alu_x(alu_x), .alu_y(alu_y), .alu_out(alu_out),
        .alu_carry(alu_carry), .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data),
        .wb_carry(wb_carry), .carry_flag(carry_flag), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    // external combinational ALU; SHL shifts y left by x[2:0], SUB carry is borrow
    always_comb begin
        alu_out   = 8'h00;
        alu_carry = 1'b0;
        case (alu_ctrl)
            4'd0:  {alu_carry, alu_out} = {1'b0, alu_x} + {1'b0, alu_y};
            4'd1:  begin alu_out = alu_x - alu_y; alu_carry = alu_x < alu_y; end
            4'd2:  alu_out = alu_x & alu_y;
            4'd3:  alu_out = alu_x | alu_y;
            4'd4:  alu_out = ~alu_x;
            4'd5:  alu_out = alu_x ^ alu_y;
            4'd6:  alu_out = ~(alu_x | alu_y);
            4'd7:  alu_out = alu_y << alu_x[2:0];
            4'd8:  alu_out = alu_y >> alu_x[2:0];
            4'd12: alu_out = {7'd0, alu_x == alu_y};
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (in_valid && in_ready && !rst) xfer_cyc.push_back(cyc);
        if (wb_valid) wb_cnt++;
        cyc++;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic [3:0] op;
        logic [2:0] rd, rs1, rs2;
        logic [7:0] imm, ex_d;
        logic       ex_c;
        logic [7:0] ex_x, ex_y;
    } vec_t;

    vec_t tbl[11];

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        total++;
        if (a !== e) $display("FAIL %s: got %0h expected %0h", n, a, e);
        else passed++;
    endtask

    task automatic drive(input logic [3:0] op, input logic [2:0] rd, rs1, rs2, input logic [7:0] imm);
        in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    endtask

    task automatic run(input vec_t v);
        int k;
        @(negedge clk);
        in_valid = 1;
        drive(v.op, v.rd, v.rs1, v.rs2, v.imm);
        k = 0;
        while (!in_ready && k < 10) begin @(negedge clk); k++; end
        chk("ready_before_issue", in_ready, 1);
        @(posedge clk);
        #1 in_valid = 0;
        k = 1;
        @(negedge clk);
        while (!wb_valid && k < 8) begin @(negedge clk); k++; end
        chk("latency", k, (v.op == 4'd15) ? 1 : 2);
        chk("wb_addr", wb_addr, v.rd);
        chk("wb_data", wb_data, v.ex_d);
        chk("wb_carry", wb_carry, v.ex_c);
        if (v.op != 4'd15) begin
            chk("alu_ctrl", alu_ctrl, v.op);
            chk("alu_x", alu_x, v.ex_x);
            chk("alu_y", alu_y, v.ex_y);
        end
        rd_addr = v.rd;
        @(negedge clk);
        chk("wb_pulse_end", wb_valid, 0);
        chk("rd_data", rd_data, v.ex_d);
        chk("carry_flag", carry_flag, v.ex_c);
        chk("ready_after", in_ready, 1);
    endtask

    initial begin
        int n0, w0;
        tbl[0]  = '{4'd15, 3'd1, 3'd0, 3'd0, 8'hF0, 8'hF0, 1'b0, 8'h00, 8'h00};
        tbl[1]  = '{4'd15, 3'd2, 3'd0, 3'd0, 8'h20, 8'h20, 1'b0, 8'h00, 8'h00};
        tbl[2]  = '{4'd0,  3'd3, 3'd1, 3'd2, 8'h00, 8'h10, 1'b1, 8'hF0, 8'h20};
        tbl[3]  = '{4'd1,  3'd4, 3'd2, 3'd1, 8'h00, 8'h30, 1'b1, 8'h20, 8'hF0};
        tbl[4]  = '{4'd1,  3'd5, 3'd1, 3'd2, 8'h00, 8'hD0, 1'b0, 8'hF0, 8'h20};
        tbl[5]  = '{4'd15, 3'd5, 3'd0, 3'd0, 8'h03, 8'h03, 1'b0, 8'h00, 8'h00};
        tbl[6]  = '{4'd15, 3'd6, 3'd0, 3'd0, 8'h11, 8'h11, 1'b0, 8'h00, 8'h00};
        tbl[7]  = '{4'd7,  3'd7, 3'd5, 3'd6, 8'h00, 8'h88, 1'b0, 8'h03, 8'h11};
        tbl[8]  = '{4'd12, 3'd0, 3'd6, 3'd6, 8'h00, 8'h01, 1'b0, 8'h11, 8'h11};
        tbl[9]  = '{4'd13, 3'd1, 3'd1, 3'd1, 8'h00, 8'h00, 1'b0, 8'hF0, 8'hF0};
        tbl[10] = '{4'd2,  3'd2, 3'd6, 3'd4, 8'h00, 8'h10, 1'b0, 8'h11, 8'h30};

        repeat (3) @(negedge clk);
        rst = 0;
        @(negedge clk);
        chk("reset_in_ready", in_ready, 1);
        chk("reset_wb_valid", wb_valid, 0);
        chk("reset_alu_x", alu_x, 0);
        chk("reset_carry_flag", carry_flag, 0);
        chk("reset_wb_data", wb_data, 0);

        for (int i = 0; i < 11; i++) run(tbl[i]);

        // back-to-back ALU ops with in_valid held high
        run('{4'd15, 3'd1, 3'd0, 3'd0, 8'hF0, 8'hF0, 1'b0, 8'h00, 8'h00});
        run('{4'd15, 3'd2, 3'd0, 3'd0, 8'h20, 8'h20, 1'b0, 8'h00, 8'h00});
        @(negedge clk);
        n0 = xfer_cyc.size();
        in_valid = 1;
        drive(4'd0, 3'd3, 3'd1, 3'd2, 8'h00);
        @(negedge clk);
        drive(4'd3, 3'd4, 3'd1, 3'd2, 8'h00);
        chk("b2b_ready_exec", in_ready, 0);
        chk("b2b_wb_exec", wb_valid, 0);
        @(negedge clk);
        chk("b2b_ready_wb", in_ready, 0);
        chk("b2b_wb1", wb_valid, 1);
        chk("b2b_add_data", wb_data, 8'h10);
        @(negedge clk);
        chk("b2b_wb1_end", wb_valid, 0);
        chk("b2b_ready_idle", in_ready, 1);
        @(negedge clk);
        in_valid = 0;
        chk("b2b_wb_exec2", wb_valid, 0);
        @(negedge clk);
        chk("b2b_wb2", wb_valid, 1);
        chk("b2b_or_data", wb_data, 8'hF0);
        @(negedge clk);
        chk("b2b_wb2_end", wb_valid, 0);
        chk("b2b_xfer_count", xfer_cyc.size() - n0, 2);
        if (xfer_cyc.size() - n0 == 2) chk("b2b_spacing", xfer_cyc[n0+1] - xfer_cyc[n0], 3);

        // set carry, then back-to-back LOADI must clear it
        run('{4'd0, 3'd3, 3'd1, 3'd2, 8'h00, 8'h10, 1'b1, 8'hF0, 8'h20});
        n0 = xfer_cyc.size();
        in_valid = 1;
        drive(4'd15, 3'd1, 3'd0, 3'd0, 8'h01);
        @(negedge clk);
        drive(4'd15, 3'd2, 3'd0, 3'd0, 8'h02);
        chk("ldi_wb1", wb_valid, 1);
        chk("ldi_data1", wb_data, 8'h01);
        chk("ldi_ready_wb", in_ready, 0);
        @(negedge clk);
        chk("ldi_ready_idle", in_ready, 1);
        chk("ldi_wb1_end", wb_valid, 0);
        @(negedge clk);
        in_valid = 0;
        chk("ldi_wb2", wb_valid, 1);
        chk("ldi_data2", wb_data, 8'h02);
        rd_addr = 3'd1;
        @(negedge clk);
        chk("ldi_spacing", (xfer_cyc.size() - n0 == 2) ? xfer_cyc[n0+1] - xfer_cyc[n0] : 0, 2);
        chk("ldi_carry_flag", carry_flag, 0);
        chk("ldi_rd_r1", rd_data, 8'h01);

        // reset during EXEC drops the instruction
        run('{4'd15, 3'd2, 3'd0, 3'd0, 8'hAA, 8'hAA, 1'b0, 8'h00, 8'h00});
        @(negedge clk);
        in_valid = 1;
        drive(4'd0, 3'd3, 3'd2, 3'd2, 8'h00);
        @(posedge clk);
        #1 in_valid = 0;
        @(negedge clk);
        chk("rst_pre_alu_x", alu_x, 8'hAA);
        w0 = wb_cnt;
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
        repeat (2) @(negedge clk);
        chk("rst_no_wb", wb_cnt - w0, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_alu_ctrl", alu_ctrl, 0);
        chk("rst_alu_x", alu_x, 0);
        chk("rst_alu_y", alu_y, 0);
        chk("rst_carry_flag", carry_flag, 0);
        for (int i = 0; i < 8; i++) begin
            rd_addr = 3'(i);
            #1 chk("rst_rf", rd_data, 0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
